display7seg_mux: RTL and testbench
==================================

// Module: display7seg_mux
// PURPOSE
//  Parametrised multiplexed 7-segment display driver, successor to the fixed 4-digit scanner.
//  Scans NUM_DIGITS common-anode/cathode digits, one slot per digit, and provides:
//   - linear PWM brightness, dead-time anti-ghosting and per-digit blanking;
//   - frame-synchronous double-buffered inputs, so a digit never changes mid-frame.
//  Sits between register/CSR logic and the board display pins.
// PARAMETERS
//  NUM_DIGITS      4  number of digits scanned (>=1)
//  BRIGHT_W        4  brightness width; MAXB = 2^BRIGHT_W-1
//  STEP            64 clk cycles per brightness step (>=1)
//  DEAD_CYCLES     4  blanked cycles at the start of every slot (>=1)
//  SEG_ACTIVE_LOW  0  1: segment pins inverted at the output
//  DIG_ACTIVE_LOW  0  1: digit pins inverted at the output
// PORTS
//  clk          in   1             system clock, rising edge
//  rst          in   1             asynchronous reset, active high
//  en           in   1             scan enable
//  brightness   in   BRIGHT_W      duty level, 0 = dark, MAXB = full slot after dead time
//  hexx         in   4*NUM_DIGITS  hex nibble per digit, digit i = hexx[4i+3:4i]
//  points       in   NUM_DIGITS    decimal point per digit, 1 = lit
//  blank        in   NUM_DIGITS    1 = digit i never driven
//  segments     out  8             {a,b,c,d,e,f,g,dp}, registered
//  digits       out  NUM_DIGITS    one-hot digit select, bit i = digit i, registered
//  frame_start  out  1             one-cycle pulse at the first cycle of digit 0's slot
// BEHAVIOUR
//  - Slot length: SLOT = DEAD_CYCLES + STEP*MAXB cycles.
//    - slot_cnt counts 0..SLOT-1, then wraps.
//    - idx advances 0..NUM_DIGITS-1 on each wrap, then returns to 0.
//  - Reset (async) clears slot_cnt, idx, shadow registers, brightness latch and frame_start.
//    - digits goes inactive: all 0, or all 1 if DIG_ACTIVE_LOW.
//    - segments goes inactive: 8'h00, or 8'hFF if SEG_ACTIVE_LOW.
//  - en=0:
//    - counters are held at 0 and outputs are inactive;
//    - shadow registers load every cycle from hexx/points/blank, and brightness is latched every cycle.
//  - Rising en: the scan starts at idx 0, slot_cnt 0.
//    - The first registered output reflects that state one cycle later.
//  - Shadow load happens when en=0, or on the cycle that idx==NUM_DIGITS-1 && slot_cnt==SLOT-1.
//    - Input changes mid-frame are not visible until the next frame.
//  - brightness is latched into b_lat at every slot_cnt==SLOT-1, and at en=0.
//  - Lit condition, registered (outputs lag slot_cnt/idx by 1 cycle):
//    slot_cnt >= DEAD_CYCLES && slot_cnt < DEAD_CYCLES + b_lat*STEP && !blank_sh[idx].
//    - When lit: digits = onehot(idx), segments = {decode(hex_sh[idx]), points_sh[idx]}.
//    - Otherwise: digits inactive, segments inactive.
//  - b_lat=0: never lit. b_lat=MAXB: lit for the whole slot except the dead cycles.
//  - Segment decode (active-high, a..g):
//    | nibble | code    | nibble | code    |
//    | 0      | 1111110 | 8      | 1111111 |
//    | 1      | 0110000 | 9      | 1111011 |
//    | 2      | 1101101 | A      | 1110111 |
//    | 3      | 1111001 | b      | 0011111 |
//    | 4      | 0110011 | C      | 1001110 |
//    | 5      | 1011011 | d      | 0111101 |
//    | 6      | 1011111 | E      | 1001111 |
//    | 7      | 1110000 | F      | 1000111 |
//  - Polarity inversion is applied last, after the register mux.
//  - frame_start: registered, high for one cycle when the outputs reflect idx==0, slot_cnt==0.
//    - It pulses regardless of brightness and blank.
//  - Simultaneous en fall and frame boundary: en=0 wins; counters go to 0 and outputs go inactive next cycle.
//  - Counter widths: slot_cnt is $clog2(SLOT) bits, idx is $clog2(NUM_DIGITS) bits (min 1).
//    - b_lat*STEP is computed at full width, with no truncation.
// TESTING (NUM_DIGITS=4, BRIGHT_W=2, STEP=2, DEAD_CYCLES=2 -> SLOT=8, frame=32)
//  1. Reset: assert rst mid-scan -> digits=4'b0000 and segments=8'h00 in the same cycle; frame_start=0.
//  2. en=1, brightness=3, hexx=16'h1234 ->
//     - digit 0: digits=4'b0001, segments=8'b0110_0110 ('4') on slot cycles 2..7 (+1 latency), dark on cycles 0..1;
//     - digit 1: shows '3' (8'b1111_0010), following the same timing.
//  3. brightness=1 -> each digit lit 2 of 8 cycles. brightness=0 -> digits stay 0, frame_start still pulses every 32 cycles.
//  4. Change hexx to 16'hABCD while digit 1 is active -> digits 2,3 still show 2,1; 'D' appears only after the next frame_start.
//  5. blank=4'b0100, points=4'b0001 -> digit 2 never selected; digit 0 segments bit0=1; other digits unchanged.
//  6. Rebuild with SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1 ->
//     - reset gives segments=8'hFF, digits=4'hF;
//     - lit digit 0 with '0' gives digits=4'b1110, segments=8'b0000_0011.

Source files
------------

// File: rtl/display7seg_mux.sv
// Multiplexed 7-segment scanner with PWM brightness, dead-time blanking,
// per-digit blanking and frame-synchronous shadowing of the display inputs.
module display7seg_mux #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned BRIGHT_W       = 4,
  parameter int unsigned STEP           = 64,
  parameter int unsigned DEAD_CYCLES    = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [BRIGHT_W-1:0]       brightness,
  input  logic [4*NUM_DIGITS-1:0]   hexx,
  input  logic [NUM_DIGITS-1:0]     points,
  input  logic [NUM_DIGITS-1:0]     blank,
  output logic [7:0]                segments,
  output logic [NUM_DIGITS-1:0]     digits,
  output logic                      frame_start
);

  localparam int unsigned MAXB = (2 ** BRIGHT_W) - 1;
  localparam int unsigned SLOT = DEAD_CYCLES + STEP * MAXB;
  localparam int unsigned CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]                 r_slot_cnt;
  logic [IW-1:0]                 r_idx;
  logic [NUM_DIGITS-1:0][3:0]    r_hex_sh;
  logic [NUM_DIGITS-1:0]         r_pts_sh;
  logic [NUM_DIGITS-1:0]         r_blank_sh;
  logic [BRIGHT_W-1:0]           r_b_lat;
  logic [7:0]                    r_seg;
  logic [NUM_DIGITS-1:0]         r_dig;
  logic                          r_frame;

  logic                          w_slot_end;
  logic                          w_frame_end;
  logic [3:0]                    w_nib;
  logic [6:0]                    w_code;
  logic [63:0]                   w_lit_end;
  logic                          w_lit;
  logic [NUM_DIGITS-1:0]         w_onehot;

  assign w_slot_end  = (r_slot_cnt == CW'(SLOT - 1));
  assign w_frame_end = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));
  assign w_nib       = r_hex_sh[r_idx];
  assign w_onehot    = NUM_DIGITS'(1) << r_idx;
  // Lit window end kept at 64 bits so b_lat*STEP never truncates.
  assign w_lit_end   = 64'(DEAD_CYCLES) + 64'(r_b_lat) * 64'(STEP);
  assign w_lit       = (64'(r_slot_cnt) >= 64'(DEAD_CYCLES)) &&
                       (64'(r_slot_cnt) < w_lit_end) && !r_blank_sh[r_idx];

  // Hex nibble to active-high {a,b,c,d,e,f,g}
  always_comb begin
    w_code = 7'b0000000;
    case (w_nib)
      4'h0: w_code = 7'b1111110;
      4'h1: w_code = 7'b0110000;
      4'h2: w_code = 7'b1101101;
      4'h3: w_code = 7'b1111001;
      4'h4: w_code = 7'b0110011;
      4'h5: w_code = 7'b1011011;
      4'h6: w_code = 7'b1011111;
      4'h7: w_code = 7'b1110000;
      4'h8: w_code = 7'b1111111;
      4'h9: w_code = 7'b1111011;
      4'hA: w_code = 7'b1110111;
      4'hB: w_code = 7'b0011111;
      4'hC: w_code = 7'b1001110;
      4'hD: w_code = 7'b0111101;
      4'hE: w_code = 7'b1001111;
      4'hF: w_code = 7'b1000111;
      default: w_code = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else if (!en) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
    end else if (w_slot_end) begin
      r_slot_cnt <= '0;
      r_idx      <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_slot_cnt <= r_slot_cnt + CW'(1);
    end
  end

  // Inputs only become visible at frame boundaries (or continuously while idle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex_sh   <= '0;
      r_pts_sh   <= '0;
      r_blank_sh <= '0;
    end else if (!en || w_frame_end) begin
      r_hex_sh   <= hexx;
      r_pts_sh   <= points;
      r_blank_sh <= blank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_lat <= '0;
    end else if (!en || w_slot_end) begin
      r_b_lat <= brightness;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg   <= '0;
      r_dig   <= '0;
      r_frame <= 1'b0;
    end else if (!en) begin
      r_seg   <= '0;
      r_dig   <= '0;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_lit ? {w_code, r_pts_sh[r_idx]} : 8'h00;
      r_dig   <= w_lit ? w_onehot : '0;
      r_frame <= (r_idx == '0) && (r_slot_cnt == '0);
    end
  end

  assign segments    = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
  assign digits      = DIG_ACTIVE_LOW ? ~r_dig : r_dig;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_display7seg_mux.sv
// Randomised bench for display7seg_mux against a frame-position model,
// with active-high and active-low builds driven in parallel.
module tb_display7seg_mux;

  localparam int ND    = 4;
  localparam int BW    = 2;
  localparam int ST    = 2;
  localparam int DC    = 2;
  localparam int SLOT  = DC + ST * 3;
  localparam int FRAME = SLOT * ND;

  logic          clk;
  logic          rst;
  logic          en;
  logic [BW-1:0] brightness;
  logic [15:0]   hexx;
  logic [3:0]    points;
  logic [3:0]    blank;
  logic [7:0]    segments,   segments_n;
  logic [3:0]    digits,     digits_n;
  logic          frame_start, frame_start_n;

  int cmp_cnt;
  int err_cnt;
  bit chk_en;

  display7seg_mux #(.NUM_DIGITS(ND), .BRIGHT_W(BW), .STEP(ST), .DEAD_CYCLES(DC),
                    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness), .hexx(hexx),
    .points(points), .blank(blank), .segments(segments), .digits(digits),
    .frame_start(frame_start));

  display7seg_mux #(.NUM_DIGITS(ND), .BRIGHT_W(BW), .STEP(ST), .DEAD_CYCLES(DC),
                    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut_n (
    .clk(clk), .rst(rst), .en(en), .brightness(brightness), .hexx(hexx),
    .points(points), .blank(blank), .segments(segments_n), .digits(digits_n),
    .frame_start(frame_start_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Model: position p inside the frame since the scan started
  int         p;
  int         m_b;
  logic [15:0] m_hex;
  logic [3:0]  m_pts;
  logic [3:0]  m_blank;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_fs;
  logic [7:0]  e_seg_n;
  logic [3:0]  e_dig_n;

  assign e_seg_n = ~e_seg;
  assign e_dig_n = ~e_dig;

  always @(posedge clk or posedge rst) begin
    int  slot;
    int  cnt;
    bit  lit;
    logic [3:0] nib;
    if (rst) begin
      p = 0; m_b = 0; m_hex = '0; m_pts = '0; m_blank = '0;
      e_seg = '0; e_dig = '0; e_fs = 1'b0;
    end else if (!en) begin
      p = 0; m_b = int'(brightness);
      m_hex = hexx; m_pts = points; m_blank = blank;
      e_seg = '0; e_dig = '0; e_fs = 1'b0;
    end else begin
      slot = p / SLOT;
      cnt  = p % SLOT;
      lit  = (cnt >= DC) && ((cnt - DC) < m_b * ST) && !m_blank[slot];
      nib  = m_hex[slot*4 +: 4];
      e_dig = lit ? 4'(1 << slot) : 4'h0;
      e_seg = lit ? {seg_tab[nib], m_pts[slot]} : 8'h00;
      e_fs  = (p == 0);
      if (cnt == SLOT - 1) m_b = int'(brightness);
      if (p == FRAME - 1) begin
        m_hex = hexx; m_pts = points; m_blank = blank;
      end
      p = (p + 1) % FRAME;
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("digits",        8'(digits),        8'(e_dig));
      check("segments",      segments,          e_seg);
      check("frame_start",   8'(frame_start),   8'(e_fs));
      check("digits_n",      8'(digits_n),      8'(e_dig_n));
      check("segments_n",    segments_n,        e_seg_n);
      check("frame_start_n", 8'(frame_start_n), 8'(e_fs));
    end
  end

  initial begin
    int r;
    cmp_cnt = 0; err_cnt = 0; chk_en = 1'b0;
    rst = 1'b1; en = 1'b0; brightness = '0; hexx = '0; points = '0; blank = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("pin_rst_dig",   8'(digits),   8'h00);
    check("pin_rst_seg",   segments,     8'h00);
    check("pin_rst_dig_n", 8'(digits_n), 8'h0F);
    check("pin_rst_seg_n", segments_n,   8'hFF);
    #1 rst = 1'b0; hexx = 16'h1234; brightness = 2'd3;
    repeat (2) @(negedge clk);
    #1 en = 1'b1;
    @(negedge clk);
    check("pin_fs_first",  8'(frame_start), 8'h01);
    check("pin_dead_dig",  8'(digits),      8'h00);
    repeat (2) @(negedge clk);
    check("pin_d0_dig",    8'(digits),      8'h01);
    check("pin_d0_seg4",   segments,        8'b0110_0110);
    repeat (8) @(negedge clk);
    check("pin_d1_dig",    8'(digits),      8'h02);
    check("pin_d1_seg3",   segments,        8'b1111_0010);
    #1 hexx = 16'hABCD;
    repeat (8) @(negedge clk);
    check("pin_d2_held",   segments,        8'b1101_1010);
    repeat (8) @(negedge clk);
    check("pin_d3_held",   segments,        8'b0110_0000);
    repeat (6) @(negedge clk);
    check("pin_fs_next",   8'(frame_start), 8'h01);
    repeat (2) @(negedge clk);
    check("pin_d0_segD",   segments,        8'b0111_1010);

    // Blanked digit 2 and decimal point on digit 0
    #1 en = 1'b0; blank = 4'b0100; points = 4'b0001; hexx = 16'h1234;
    @(negedge clk);
    #1 en = 1'b1;
    repeat (3) @(negedge clk);
    check("pin_dp_seg",    segments,        8'b0110_0111);
    repeat (16) @(negedge clk);
    check("pin_blank_dig", 8'(digits),      8'h00);

    // Active-low build showing '0' on digit 0
    #1 en = 1'b0; blank = '0; points = '0; hexx = 16'h0000;
    @(negedge clk);
    #1 en = 1'b1;
    repeat (3) @(negedge clk);
    check("pin_inv_dig",   8'(digits_n),    8'h0E);
    check("pin_inv_seg",   segments_n,      8'b0000_0011);

    // Mid-slot asynchronous reset
    #1 rst = 1'b1;
    #1;
    check("pin_arst_dig",  8'(digits),      8'h00);
    check("pin_arst_seg",  segments,        8'h00);
    check("pin_arst_fs",   8'(frame_start), 8'h00);
    @(negedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      r = int'($urandom_range(0, 999));
      if (rst) rst = 1'b0;
      else if (r < 3) rst = 1'b1;
      if (en && r >= 990) en = 1'b0;
      else if (!en && r < 300) en = 1'b1;
      if ($urandom_range(0, 19) == 0) brightness = BW'($urandom);
      if ($urandom_range(0, 29) == 0) hexx = 16'($urandom);
      if ($urandom_range(0, 39) == 0) points = 4'($urandom);
      if ($urandom_range(0, 39) == 0) blank = 4'($urandom & $urandom);
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
